// File: rtl/uart_pkg.sv
// Shared definitions for the parity UART link (receiver and transmitter).
// Holds the receiver state encoding, the parity-sense constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // XOR-reduce of a payload; narrower payloads are zero-extended.
    function automatic logic parity_calc(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to 1.
// Ports: clk_i, rst_i (sync, active-high), d_i async input, q_o synchronised output.
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with parity: 1 start, DATA_BITS data (LSB first), 1 parity, 1 stop.
// Ports: clk, rst (sync, active-high), rxd serial in; dout, done strobe,
// parity_err, frame_err (held until next done), busy (state != IDLE).
module uart_rx_parity #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    logic rx_s;

    rx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic pbit_q, pbit_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic done_q, done_d;
    logic perr_q, perr_d;
    logic ferr_q, ferr_d;

    uart_rx_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (rxd),
        .q_o  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            pbit_q  <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            pbit_q  <= pbit_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pbit_d  = pbit_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    pbit_d  = rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    dout_d  = sh_q;
                    perr_d  = parity_calc(8'(sh_q)) ^ pbit_q ^ ODD;
                    ferr_d  = ~rx_s;
                    done_d  = 1'b1;
                    state_d = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Held-low line: no more frames until it returns high.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign done       = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- Standalone UART receiver with parity check, forming the receive end of the team's parity UART link.
- Deserialises one asynchronous serial line (8N/parity/1 framing, LSB first) into bytes.
- Flags parity and framing errors, and presents each byte with a one-cycle done strobe to the local consumer.
- Sits behind the board rx pin, or is looped to a parity UART transmitter for link tests.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be even and >= 4.
- DATA_BITS, 8: payload bits per frame. Range 5..8.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rxd  in  1  asynchronous serial input; idles high.
- dout  out  DATA_BITS  last received payload; holds until the next frame completes.
- done  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity mismatch for the frame just completed; valid with done, held until the next done.
- frame_err  out  1  stop bit sampled low; valid with done, held until the next done.
- busy  out  1  high from start detection until return to IDLE.

Behaviour:
- Reset is synchronous, active-high.
  - All outputs go to 0 and dout to 0.
  - FSM goes to IDLE; counters clear.
  - Both synchroniser flops load 1, so a rxd held low through reset cannot fake a start bit.
- rxd passes through a 2-flop synchroniser, giving rx_s.
  - All timing below is relative to rx_s.
  - Pin-to-rx_s delay is 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE
  - Edge t0 where rx_s==0: go to START, clear the cycle counter, busy=1 from t0+1.
- START
  - At t0+C/2 (C=CLKS_PER_BIT), sample rx_s.
  - Sample 1: glitch. Return to IDLE, busy=0, no done.
  - Sample 0: go to DATA, bit index 0.
- DATA
  - Bit i is sampled at t0+C/2+(i+1)*C and shifted in LSB first.
  - After bit DATA_BITS-1, go to PARITY.
- PARITY
  - Sample at t0+C/2+(DATA_BITS+1)*C.
  - parity_err = XOR(payload, parity bit) XOR PARITY_ODD, i.e. must equal 0.
- STOP
  - Sample at ts = t0+C/2+(DATA_BITS+2)*C.
  - At edge ts, register all of: dout, parity_err, frame_err = ~rx_s, done=1.
  - These are visible in cycle ts+1. done falls at ts+2.
  - Stop bit 1: go to IDLE at ts. The next falling edge may be accepted from ts+1, giving back-to-back frames with no idle gap.
  - Stop bit 0: go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. No further done strobes during a held-low line.
- dout is loaded even when an error is flagged; errors are advisory.
- busy = (state != IDLE).
- rst asserted mid-frame: abort; no done for the partial frame.
- A counter-width parameter is derived as clog2(CLKS_PER_BIT).
- DATA_BITS < 8: dout is DATA_BITS wide. No padding inside this block.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - PARITY_EVEN/PARITY_ODD constants;
  - the parity function, shared with the transmitter.
- One sub-module, uart_rx_sync: 2-flop synchroniser with a reset value of 1 and parameterisable width. It is reused by other async inputs.
- FSM, bit counter and shift register stay in this module.

Test Plan:
- Frame 0xC1, even parity, C=16: rxd bits start 0, data 1,0,0,0,0,0,1,1, parity 1, stop 1 -> done pulses once at ts+1; dout=0xC1, parity_err=0, frame_err=0.
- 0x81 sent back-to-back with no idle gap after 0xC1, parity bit 0 -> two done pulses exactly 11*C cycles apart; dout=0xC1 then 0x81; no errors.
- 0x81 with parity bit forced to 1 -> done=1, dout=0x81, parity_err=1, frame_err=0. With PARITY_ODD=1 and parity bit 1 -> parity_err=0.
- 0xC1 with stop bit 0, then rxd held low 40*C cycles -> exactly one done with frame_err=1. busy stays 1 until rxd returns high, then 0 two cycles later. The next valid frame is received cleanly.
- rxd low pulse of C/2-1 cycles from idle -> busy rises then falls, no done, dout unchanged.
- rst pulsed for 1 cycle during data bit 3 -> outputs 0 the next cycle, no done. A fresh 0x81 frame afterwards gives dout=0x81 with no errors.
